// File: rtl/core_clock_ctrl.sv
// Core clock/reset sequencer: divides clk50 into the CPU core clock and adds
// free-run, halt, single-step, N-cycle burst and breakpoint control plus reset sequencing.
module core_clock_ctrl #(
    parameter int DIV        = 2,
    parameter int POR_CYCLES = 33554432,
    parameter int DEB_CYCLES = 500000,
    parameter int BURST_W    = 16,
    parameter int CNT_W      = 32
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               key_rst_n,
    input  logic               soft_rst_req,
    input  logic               run_sw,
    input  logic               step_key_n,
    input  logic               break_req,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               core_clk,
    output logic               core_rise,
    output logic               core_rst,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int POR_W = (POR_CYCLES > 0) ? $clog2(POR_CYCLES + 1) : 1;
    localparam int DEB_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [POR_W-1:0] POR_MAX  = POR_W'(POR_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_HALT,
        ST_STEP,
        ST_BURST
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               clk_nxt;
    logic [BURST_W-1:0] remain;
    logic [BURST_W-1:0] remain_nxt;

    logic               key_meta;
    logic               key_sync;
    logic               step_meta;
    logic               step_sync;
    logic [PRE_W-1:0]   pre;
    logic               tick;
    logic [POR_W-1:0]   por_cnt;
    logic               por_done;
    logic               reset_cause;
    logic               deb_level;
    logic [DEB_W-1:0]   deb_cnt;
    logic               step_evt;

    // Synchronisers idle high so a block reset alone does not lengthen the POR sequence.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            step_meta <= 1'b1;
            step_sync <= 1'b1;
        end else begin
            key_meta  <= key_rst_n;
            key_sync  <= key_meta;
            step_meta <= step_key_n;
            step_sync <= step_meta;
        end
    end

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    assign reset_cause = ~key_sync | soft_rst_req;
    assign por_done    = (por_cnt == POR_MAX);

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            por_cnt <= '0;
        end else if (reset_cause) begin
            por_cnt <= '0;
        end else if (!por_done) begin
            por_cnt <= por_cnt + POR_W'(1);
        end
    end

    // The key must differ from the accepted level for DEB_CYCLES straight cycles to be taken.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            step_evt  <= 1'b0;
        end else begin
            step_evt <= 1'b0;
            if (step_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= step_sync;
                deb_cnt   <= '0;
                step_evt  <= ~step_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        clk_nxt    = core_clk;
        remain_nxt = remain;
        if (reset_cause) begin
            state_nxt  = ST_RESET;
            clk_nxt    = 1'b0;
            remain_nxt = '0;
        end else begin
            case (state)
                ST_RESET: begin
                    clk_nxt = 1'b0;
                    if (por_done) begin
                        state_nxt = run_sw ? ST_RUN : ST_HALT;
                    end
                end
                ST_RUN: begin
                    // Halting only from the high phase keeps every core cycle complete.
                    if (tick) begin
                        if (core_clk && (break_req || !run_sw)) begin
                            clk_nxt   = 1'b0;
                            state_nxt = ST_HALT;
                        end else begin
                            clk_nxt = ~core_clk;
                        end
                    end
                end
                ST_HALT: begin
                    clk_nxt = 1'b0;
                    if (step_evt) begin
                        state_nxt = ST_STEP;
                    end else if (burst_start && (burst_len != '0)) begin
                        state_nxt  = ST_BURST;
                        remain_nxt = burst_len;
                    end else if (run_sw && !break_req) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (tick) begin
                        clk_nxt = ~core_clk;
                        if (core_clk) begin
                            state_nxt = ST_HALT;
                        end
                    end
                end
                ST_BURST: begin
                    if (tick) begin
                        clk_nxt = ~core_clk;
                        if (core_clk) begin
                            remain_nxt = remain - BURST_W'(1);
                            if ((remain == BURST_W'(1)) || break_req) begin
                                state_nxt = ST_HALT;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RESET;
                    clk_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state so they all switch on the same clk50 edge.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            remain      <= '0;
            core_clk    <= 1'b0;
            core_rise   <= 1'b0;
            core_rst    <= 1'b1;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= state_nxt;
            remain    <= remain_nxt;
            core_clk  <= clk_nxt;
            core_rise <= clk_nxt & ~core_clk;
            core_rst  <= (state_nxt == ST_RESET);
            halted    <= (state_nxt == ST_HALT);
            if (state_nxt == ST_RESET) begin
                cycle_count <= '0;
            end else if (clk_nxt && !core_clk) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Scoreboard bench for core_clock_ctrl: stimulus queues the core rises it expects,
// a negedge monitor pops one per observed core_rise and checks the cycle counter.
module tb_core_clock_ctrl;

    localparam int DIV = 2;
    localparam int POR = 16;
    localparam int DEB = 8;
    localparam int BW  = 16;
    localparam int CW  = 32;

    localparam int OP_BURST  = 0;
    localparam int OP_KEY    = 1;
    localparam int OP_SOFT   = 2;
    localparam int OP_KEYRST = 3;

    logic          clk50 = 1'b0;
    logic          rst_n;
    logic          key_rst_n;
    logic          soft_rst_req;
    logic          run_sw;
    logic          step_key_n;
    logic          break_req;
    logic          burst_start;
    logic [BW-1:0] burst_len;
    logic          core_clk;
    logic          core_rise;
    logic          core_rst;
    logic          halted;
    logic [CW-1:0] cycle_count;

    int    checks      = 0;
    int    errors      = 0;
    int    cyc         = 0;
    int    refCount    = 0;
    int    freeStreak  = 0;
    int    lastRiseCyc = 0;
    bit    allowFree   = 1'b0;
    string expQ[$];
    string monTag;

    core_clock_ctrl #(
        .DIV(DIV), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .BURST_W(BW), .CNT_W(CW)
    ) dut (
        .clk50(clk50), .rst_n(rst_n), .key_rst_n(key_rst_n), .soft_rst_req(soft_rst_req),
        .run_sw(run_sw), .step_key_n(step_key_n), .break_req(break_req),
        .burst_start(burst_start), .burst_len(burst_len), .core_clk(core_clk),
        .core_rise(core_rise), .core_rst(core_rst), .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk50 = ~clk50;

    always @(posedge clk50) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // The reference count restarts whenever the core is held in reset.
    always @(negedge clk50) begin
        if (!rst_n || core_rst) begin
            refCount   = 0;
            freeStreak = 0;
        end else begin
            if (!allowFree) freeStreak = 0;
            if (core_rise) begin
                if (expQ.size() > 0) begin
                    monTag = expQ.pop_front();
                    refCount++;
                    checkOutput({monTag, "_count"}, cycle_count, refCount);
                end else if (allowFree) begin
                    if (freeStreak > 0) checkOutput("free_period", cyc - lastRiseCyc, 2 * DIV);
                    freeStreak++;
                    refCount++;
                    checkOutput("free_count", cycle_count, refCount);
                end else begin
                    checkOutput("unexpected_rise", core_rise, 0);
                end
                checkOutput("clk_high_at_rise", core_clk, 1);
                lastRiseCyc = cyc;
            end
        end
    end

    task automatic nextCycle(input int n = 1);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic applyStimulus(input int op, input int value);
        case (op)
            OP_BURST: begin
                burst_len   = BW'(value);
                burst_start = 1'b1;
                nextCycle(1);
                burst_start = 1'b0;
            end
            OP_KEY: begin
                step_key_n = 1'b0;
                nextCycle(value);
                step_key_n = 1'b1;
            end
            OP_SOFT: begin
                soft_rst_req = 1'b1;
                nextCycle(1);
                soft_rst_req = 1'b0;
            end
            default: begin
                key_rst_n = 1'b0;
                nextCycle(value);
                key_rst_n = 1'b1;
            end
        endcase
    endtask

    task automatic measurePor(input string name, input int expected, input int budget);
        int n = 0;
        for (int i = 0; i < budget; i++) begin
            nextCycle(1);
            n++;
            if (!core_rst) break;
        end
        checkOutput(name, n, expected);
    endtask

    task automatic waitQuiet(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            nextCycle(1);
            if (expQ.size() == 0 && halted) break;
        end
        nextCycle(6);
        checkOutput({name, "_drained"}, expQ.size(), 0);
        checkOutput({name, "_halted"}, halted, 1);
        checkOutput({name, "_clk_low"}, core_clk, 0);
        checkOutput({name, "_frozen"}, cycle_count, refCount);
    endtask

    task automatic waitRefCount(input string name, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (refCount >= target) break;
            nextCycle(1);
        end
        checkOutput({name, "_reached"}, refCount >= target, 1);
    endtask

    task automatic riseThen(input int k, input int budget);
        int seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (core_rise) seen++;
            if (seen == k) break;
            nextCycle(1);
        end
        checkOutput("rise_wait", seen, k);
    endtask

    initial begin
        int n;
        int k;
        rst_n        = 1'b0;
        key_rst_n    = 1'b1;
        soft_rst_req = 1'b0;
        run_sw       = 1'b1;
        step_key_n   = 1'b1;
        break_req    = 1'b0;
        burst_start  = 1'b0;
        burst_len    = '0;
        nextCycle(3);
        checkOutput("reset_core_clk", core_clk, 0);
        checkOutput("reset_core_rise", core_rise, 0);
        checkOutput("reset_core_rst", core_rst, 1);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_count", cycle_count, 0);

        $display("[TB] power-on and free run");
        rst_n = 1'b1;
        measurePor("por_release", POR + 1, 60);
        checkOutput("por_run_not_halted", halted, 0);
        allowFree = 1'b1;
        waitRefCount("run5", 5, 100);
        checkOutput("run_count_5", cycle_count, 5);
        nextCycle($urandom_range(0, 12));

        $display("[TB] breakpoint halt");
        for (int i = 0; i < 10 && core_clk; i++) nextCycle(1);
        allowFree = 1'b0;
        expQ.push_back("break");
        break_req = 1'b1;
        waitQuiet("break", 40);
        nextCycle(10);
        checkOutput("break_hold_count", cycle_count, refCount);
        run_sw    = 1'b0;
        break_req = 1'b0;
        nextCycle(4);
        checkOutput("halt_held", halted, 1);

        $display("[TB] single step and glitch");
        n = $urandom_range(1, 3);
        for (int s = 0; s < n; s++) begin
            expQ.push_back("step");
            applyStimulus(OP_KEY, 20);
            waitQuiet("step", 60);
            nextCycle(15);
        end
        applyStimulus(OP_KEY, 5);
        nextCycle(30);
        checkOutput("glitch5_count", cycle_count, refCount);
        applyStimulus(OP_KEY, $urandom_range(1, DEB - 1));
        nextCycle(30);
        checkOutput("glitch_rand_count", cycle_count, refCount);
        checkOutput("glitch_halted", halted, 1);

        $display("[TB] bursts");
        for (int b = 0; b < 3; b++) begin
            k = $urandom_range(1, 6);
            for (int r = 0; r < k; r++) expQ.push_back("burst");
            applyStimulus(OP_BURST, k);
            waitQuiet("burst", k * 4 * DIV + 40);
        end
        applyStimulus(OP_BURST, 0);
        nextCycle(20);
        checkOutput("burst_zero_count", cycle_count, refCount);
        checkOutput("burst_zero_halted", halted, 1);

        $display("[TB] burst abort");
        k = $urandom_range(2, 6);
        for (int r = 0; r < k; r++) expQ.push_back("abort");
        applyStimulus(OP_BURST, 10);
        riseThen(k, 200);
        break_req = 1'b1;
        waitQuiet("abort", 60);
        break_req = 1'b0;

        $display("[TB] key reset");
        applyStimulus(OP_KEYRST, 4);
        checkOutput("keyrst_core_rst", core_rst, 1);
        checkOutput("keyrst_count", cycle_count, 0);
        measurePor("keyrst_por", POR + 3, 60);
        checkOutput("keyrst_halted", halted, 1);

        $display("[TB] soft reset mid-burst");
        k = $urandom_range(2, 4);
        for (int r = 0; r < k; r++) expQ.push_back("soft");
        applyStimulus(OP_BURST, 8);
        riseThen(k, 200);
        applyStimulus(OP_SOFT, 0);
        checkOutput("soft_core_rst", core_rst, 1);
        checkOutput("soft_core_clk", core_clk, 0);
        checkOutput("soft_count", cycle_count, 0);
        checkOutput("soft_halted", halted, 0);
        run_sw = 1'($urandom_range(0, 1));
        measurePor("soft_por", POR + 1, 60);
        checkOutput("soft_queue", expQ.size(), 0);
        if (run_sw) begin
            checkOutput("soft_run_not_halted", halted, 0);
            allowFree = 1'b1;
            waitRefCount("soft_run5", 5, 100);
            checkOutput("soft_run_count_5", cycle_count, 5);
        end else begin
            nextCycle(20);
            checkOutput("soft_halt_halted", halted, 1);
            checkOutput("soft_halt_count", cycle_count, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
